// File: rtl/dll_core.sv
// -----------------------------------------------------------------------------
// dll_core -- doubly linked list engine (responder side of the DLL op interface)
//
// Holds up to MAX_NODE nodes of DATA_WIDTH-bit payload in register storage.
// Every node has its own prev/next pointers, and a valid map records which
// slots are in use. Address 2**ADDR_WIDTH-1 acts as NULL.
//
// Optional feature macro: DLL_CORE_DELETE_VALUE_EN
//   defined   : op 7 (DELETE_VALUE) walks the list one node per cycle in SEARCH
//   undefined : SEARCH and the comparator are absent; op 7 always faults
//
// Ports
//   clk, rst        clock; asynchronous active-low reset
//   data_in         payload for inserts / match value for DELETE_VALUE
//   addr_in         target node for READ_ADDR / INSERT_AFTER / DELETE_ADDR
//   op, op_start    opcode and request strobe (accepted only when idle)
//   op_done         one-cycle completion pulse
//   fault           op rejected; updates with op_done, then holds
//   data_out        read data / inserted data / deleted data
//   pre_node_addr   prev pointer of the result node
//   next_node_addr  next pointer of the result node
//   length          number of valid nodes
//   head, tail      list ends (NULL when empty)
//   full, empty     length==MAX_NODE / length==0
// -----------------------------------------------------------------------------
module dll_core #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int MAX_NODE   = 2**ADDR_WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [2:0]            op,
    input  logic                  op_start,
    output logic                  op_done,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH-1:0] pre_node_addr,
    output logic [ADDR_WIDTH-1:0] next_node_addr,
    output logic [ADDR_WIDTH-1:0] length,
    output logic [ADDR_WIDTH-1:0] head,
    output logic [ADDR_WIDTH-1:0] tail,
    output logic                  full,
    output logic                  empty,
    output logic                  fault
);

    localparam int                    NSLOT  = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] NULL_A = '1;
    localparam logic [ADDR_WIDTH-1:0] CAP    = ADDR_WIDTH'(MAX_NODE);

    localparam logic [2:0] OP_READ      = 3'd0;
    localparam logic [2:0] OP_INS_HEAD  = 3'd1;
    localparam logic [2:0] OP_INS_TAIL  = 3'd2;
    localparam logic [2:0] OP_INS_AFTER = 3'd3;
    localparam logic [2:0] OP_DEL_ADDR  = 3'd4;
    localparam logic [2:0] OP_DEL_HEAD  = 3'd5;
    localparam logic [2:0] OP_DEL_TAIL  = 3'd6;
    localparam logic [2:0] OP_DEL_VAL   = 3'd7;

`ifdef DLL_CORE_DELETE_VALUE_EN
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SEARCH, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
`endif

    state_t r_state, w_state_nxt;

    // latched request
    logic [2:0]            r_op;
    logic [DATA_WIDTH-1:0] r_din;
    logic [ADDR_WIDTH-1:0] r_ain;

    // node storage; slot NULL_A exists only so a NULL index reads harmlessly
    logic [DATA_WIDTH-1:0] r_mem  [NSLOT];
    logic [ADDR_WIDTH-1:0] r_prev [NSLOT];
    logic [ADDR_WIDTH-1:0] r_next [NSLOT];
    logic [MAX_NODE-1:0]   r_valid;

    // list status and result registers
    logic [ADDR_WIDTH-1:0] r_head, r_tail, r_len;
    logic                  r_full, r_empty;
    logic                  r_done, r_fault;
    logic [DATA_WIDTH-1:0] r_dout;
    logic [ADDR_WIDTH-1:0] r_pre, r_nxt;

`ifdef DLL_CORE_DELETE_VALUE_EN
    // search cursor; holds the matching node (or NULL) when SEARCH exits
    logic [ADDR_WIDTH-1:0] r_cur;
    logic                  w_hit;
    assign w_hit = (r_mem[r_cur] == r_din);
`endif

    // ---------------------------------------------------------------- decode
    logic [MAX_NODE:0]     w_valid_ext;
    logic                  w_addr_ok;
    logic [ADDR_WIDTH-1:0] w_free;

    // NULL maps onto the always-zero top bit, so it never looks allocated
    assign w_valid_ext = {1'b0, r_valid};
    assign w_addr_ok   = w_valid_ext[r_ain];

    // lowest free slot wins
    always_comb begin
        w_free = NULL_A;
        for (int i = MAX_NODE - 1; i >= 0; i--) begin
            if (!r_valid[i]) w_free = ADDR_WIDTH'(i);
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (op_start) w_state_nxt = S_EXEC;
`ifdef DLL_CORE_DELETE_VALUE_EN
            S_EXEC: w_state_nxt = (r_op == OP_DEL_VAL) ? S_SEARCH : S_DONE;
            // the NULL check costs its own cycle, giving length+3 on a miss
            S_SEARCH: if (r_cur == NULL_A || w_hit) w_state_nxt = S_DONE;
`else
            S_EXEC: w_state_nxt = S_DONE;
`endif
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- commit
    // All list mutation happens on the DONE->IDLE edge, together with the
    // op_done rise. An insert writes the new node plus at most one next and
    // one prev fix-up; a delete needs just the two fix-ups.
    logic                  w_fault, w_del, w_new_en;
    logic [ADDR_WIDTH-1:0] w_tgt, w_new_prev, w_new_next;
    logic                  w_lnk_n_en, w_lnk_p_en;
    logic [ADDR_WIDTH-1:0] w_lnk_n_addr, w_lnk_n_val, w_lnk_p_addr, w_lnk_p_val;
    logic [ADDR_WIDTH-1:0] w_head_nxt, w_tail_nxt, w_len_nxt;
    logic [MAX_NODE-1:0]   w_valid_nxt;
    logic [DATA_WIDTH-1:0] w_dout_nxt;
    logic [ADDR_WIDTH-1:0] w_pre_nxt, w_nxt_nxt;

    always_comb begin
        w_fault      = 1'b0;
        w_del        = 1'b0;
        w_tgt        = NULL_A;
        w_new_en     = 1'b0;
        w_new_prev   = NULL_A;
        w_new_next   = NULL_A;
        w_lnk_n_en   = 1'b0;
        w_lnk_n_addr = NULL_A;
        w_lnk_n_val  = NULL_A;
        w_lnk_p_en   = 1'b0;
        w_lnk_p_addr = NULL_A;
        w_lnk_p_val  = NULL_A;
        w_head_nxt   = r_head;
        w_tail_nxt   = r_tail;
        w_len_nxt    = r_len;
        w_valid_nxt  = r_valid;
        w_dout_nxt   = r_dout;
        w_pre_nxt    = r_pre;
        w_nxt_nxt    = r_nxt;

        if (r_state == S_DONE) begin
            case (r_op)
                OP_READ: begin
                    if (!w_addr_ok) w_fault = 1'b1;
                    else begin
                        w_dout_nxt = r_mem[r_ain];
                        w_pre_nxt  = r_prev[r_ain];
                        w_nxt_nxt  = r_next[r_ain];
                    end
                end
                OP_INS_HEAD: begin
                    if (r_full) w_fault = 1'b1;
                    else begin
                        w_new_en   = 1'b1;
                        w_new_next = r_head;
                        if (r_head != NULL_A) begin
                            w_lnk_p_en   = 1'b1;
                            w_lnk_p_addr = r_head;
                            w_lnk_p_val  = w_free;
                        end else begin
                            w_tail_nxt = w_free;
                        end
                        w_head_nxt = w_free;
                    end
                end
                OP_INS_TAIL: begin
                    if (r_full) w_fault = 1'b1;
                    else begin
                        w_new_en   = 1'b1;
                        w_new_prev = r_tail;
                        if (r_tail != NULL_A) begin
                            w_lnk_n_en   = 1'b1;
                            w_lnk_n_addr = r_tail;
                            w_lnk_n_val  = w_free;
                        end else begin
                            w_head_nxt = w_free;
                        end
                        w_tail_nxt = w_free;
                    end
                end
                OP_INS_AFTER: begin
                    if (r_full || !w_addr_ok) w_fault = 1'b1;
                    else begin
                        w_new_en     = 1'b1;
                        w_new_prev   = r_ain;
                        w_new_next   = r_next[r_ain];
                        w_lnk_n_en   = 1'b1;
                        w_lnk_n_addr = r_ain;
                        w_lnk_n_val  = w_free;
                        if (r_next[r_ain] != NULL_A) begin
                            w_lnk_p_en   = 1'b1;
                            w_lnk_p_addr = r_next[r_ain];
                            w_lnk_p_val  = w_free;
                        end else begin
                            w_tail_nxt = w_free;
                        end
                    end
                end
                OP_DEL_ADDR: begin
                    w_tgt   = r_ain;
                    w_fault = !w_addr_ok;
                    w_del   = w_addr_ok;
                end
                OP_DEL_HEAD: begin
                    w_tgt   = r_head;
                    w_fault = r_empty;
                    w_del   = !r_empty;
                end
                OP_DEL_TAIL: begin
                    w_tgt   = r_tail;
                    w_fault = r_empty;
                    w_del   = !r_empty;
                end
                OP_DEL_VAL: begin
`ifdef DLL_CORE_DELETE_VALUE_EN
                    w_tgt   = r_cur;
                    w_fault = (r_cur == NULL_A);
                    w_del   = (r_cur != NULL_A);
`else
                    w_fault = 1'b1;
`endif
                end
                default: w_fault = 1'b1;
            endcase

            if (w_new_en) begin
                w_valid_nxt[w_free] = 1'b1;
                w_len_nxt           = r_len + 1'b1;
                w_dout_nxt          = r_din;
                w_pre_nxt           = w_new_prev;
                w_nxt_nxt           = w_new_next;
            end

            // unlink: neighbours bypass the target, ends move when it was one
            if (w_del) begin
                w_dout_nxt = r_mem[w_tgt];
                w_pre_nxt  = r_prev[w_tgt];
                w_nxt_nxt  = r_next[w_tgt];
                if (r_prev[w_tgt] != NULL_A) begin
                    w_lnk_n_en   = 1'b1;
                    w_lnk_n_addr = r_prev[w_tgt];
                    w_lnk_n_val  = r_next[w_tgt];
                end else begin
                    w_head_nxt = r_next[w_tgt];
                end
                if (r_next[w_tgt] != NULL_A) begin
                    w_lnk_p_en   = 1'b1;
                    w_lnk_p_addr = r_next[w_tgt];
                    w_lnk_p_val  = r_prev[w_tgt];
                end else begin
                    w_tail_nxt = r_prev[w_tgt];
                end
                w_valid_nxt[w_tgt] = 1'b0;
                w_len_nxt          = r_len - 1'b1;
            end
        end
    end

    // node payload/links carry no reset: the valid map alone defines contents
    always_ff @(posedge clk) begin
        if (w_new_en) begin
            r_mem[w_free]  <= r_din;
            r_prev[w_free] <= w_new_prev;
            r_next[w_free] <= w_new_next;
        end
        if (w_lnk_n_en) r_next[w_lnk_n_addr] <= w_lnk_n_val;
        if (w_lnk_p_en) r_prev[w_lnk_p_addr] <= w_lnk_p_val;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op    <= 3'd0;
            r_din   <= '0;
            r_ain   <= NULL_A;
            r_valid <= '0;
            r_head  <= NULL_A;
            r_tail  <= NULL_A;
            r_len   <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_done  <= 1'b0;
            r_fault <= 1'b0;
            r_dout  <= '0;
            r_pre   <= NULL_A;
            r_nxt   <= NULL_A;
`ifdef DLL_CORE_DELETE_VALUE_EN
            r_cur   <= NULL_A;
`endif
        end else begin
            r_done <= (r_state == S_DONE);
            if (r_state == S_IDLE && op_start) begin
                r_op  <= op;
                r_din <= data_in;
                r_ain <= addr_in;
            end
            if (r_state == S_DONE) begin
                r_fault <= w_fault;
                r_dout  <= w_dout_nxt;
                r_pre   <= w_pre_nxt;
                r_nxt   <= w_nxt_nxt;
                r_head  <= w_head_nxt;
                r_tail  <= w_tail_nxt;
                r_len   <= w_len_nxt;
                r_valid <= w_valid_nxt;
                r_full  <= (w_len_nxt == CAP);
                r_empty <= (w_len_nxt == '0);
            end
`ifdef DLL_CORE_DELETE_VALUE_EN
            if (r_state == S_EXEC)
                r_cur <= r_head;
            else if (r_state == S_SEARCH && r_cur != NULL_A && !w_hit)
                r_cur <= r_next[r_cur];
`endif
        end
    end

    assign op_done        = r_done;
    assign fault          = r_fault;
    assign data_out       = r_dout;
    assign pre_node_addr  = r_pre;
    assign next_node_addr = r_nxt;
    assign length         = r_len;
    assign head           = r_head;
    assign tail           = r_tail;
    assign full           = r_full;
    assign empty          = r_empty;

endmodule

// File: tb/tb_dll_core.sv
// -----------------------------------------------------------------------------
// tb_dll_core -- self-checking bench for dll_core.
// Reference model keeps the list as a queue of slot indices in list order;
// prev/next/head/tail are read off queue positions.
// -----------------------------------------------------------------------------
module tb_dll_core;

    localparam logic [3:0] NUL = 4'hF;
    localparam logic [2:0] RD = 3'd0, IH = 3'd1, IT = 3'd2, IA = 3'd3,
                           DA = 3'd4, DH = 3'd5, DT = 3'd6, DV = 3'd7;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = '0;
    logic [3:0] addr_in = '0;
    logic [2:0] op = '0;
    logic       op_start = 1'b0;
    logic       op_done, full, empty, fault;
    logic [7:0] data_out;
    logic [3:0] pre_node_addr, next_node_addr, length, head, tail;

    always #5 clk = ~clk;

    dll_core #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .addr_in(addr_in),
        .op(op), .op_start(op_start), .op_done(op_done),
        .data_out(data_out), .pre_node_addr(pre_node_addr),
        .next_node_addr(next_node_addr), .length(length),
        .head(head), .tail(tail), .full(full), .empty(empty), .fault(fault)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------ model
    int         q[$];
    logic [7:0] mmem [15];
    bit         mused[15];
    logic [7:0] e_dout;
    logic [3:0] e_pre, e_nxt;
    logic       e_fault;
    int         e_lat;

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 15; i++) mused[i] = 1'b0;
        e_dout = '0; e_pre = NUL; e_nxt = NUL; e_fault = 1'b0;
    endtask

    function automatic int pos_of(input logic [3:0] a);
        if (a == NUL) return -1;
        for (int i = 0; i < q.size(); i++) if (q[i] == int'(a)) return i;
        return -1;
    endfunction

    function automatic logic [3:0] prv(input int p);
        return (p > 0) ? 4'(q[p-1]) : NUL;
    endfunction

    function automatic logic [3:0] nxt(input int p);
        return (p < q.size() - 1) ? 4'(q[p+1]) : NUL;
    endfunction

    function automatic logic [3:0] e_head();
        return (q.size() > 0) ? 4'(q[0]) : NUL;
    endfunction

    function automatic logic [3:0] e_tail();
        return (q.size() > 0) ? 4'(q[q.size()-1]) : NUL;
    endfunction

    function automatic int lowest_free();
        for (int i = 0; i < 15; i++) if (!mused[i]) return i;
        return -1;
    endfunction

    task automatic model_op(input logic [2:0] o, input logic [7:0] d, input logic [3:0] a);
        int p, n, s, sz;
        bit del;
        sz = q.size(); e_lat = 2; p = -1; del = 1'b0;
        case (o)
            RD: begin
                p = pos_of(a);
                if (p < 0) e_fault = 1'b1;
                else begin e_fault = 1'b0; e_dout = mmem[a]; e_pre = prv(p); e_nxt = nxt(p); end
            end
            IH, IT, IA: begin
                p = (o == IA) ? pos_of(a) : 0;
                if (sz == 15 || p < 0) e_fault = 1'b1;
                else begin
                    n = lowest_free();
                    mused[n] = 1'b1; mmem[n] = d;
                    e_fault = 1'b0; e_dout = d;
                    if (o == IH) begin
                        e_pre = NUL; e_nxt = e_head(); q.push_front(n);
                    end else if (o == IT) begin
                        e_pre = e_tail(); e_nxt = NUL; q.push_back(n);
                    end else begin
                        e_pre = a; e_nxt = nxt(p); q.insert(p + 1, n);
                    end
                end
            end
            DA: begin p = pos_of(a); del = 1'b1; end
            DH: begin p = (sz > 0) ? 0 : -1; del = 1'b1; end
            DT: begin p = (sz > 0) ? sz - 1 : -1; del = 1'b1; end
            default: begin
`ifdef DLL_CORE_DELETE_VALUE_EN
                for (int i = 0; i < sz; i++) if (p < 0 && mmem[q[i]] == d) p = i;
                e_lat = 3 + ((p >= 0) ? p : sz);
`endif
                del = 1'b1;
            end
        endcase
        if (del) begin
            if (p < 0) e_fault = 1'b1;
            else begin
                s = q[p];
                e_fault = 1'b0; e_dout = mmem[s]; e_pre = prv(p); e_nxt = nxt(p);
                q.delete(p); mused[s] = 1'b0;
            end
        end
    endtask

    // ------------------------------------------------------------ helpers
    task automatic compare_all(input string tag);
        chk({tag, " fault"},  32'(fault),          32'(e_fault));
        chk({tag, " data"},   32'(data_out),       32'(e_dout));
        chk({tag, " pre"},    32'(pre_node_addr),  32'(e_pre));
        chk({tag, " next"},   32'(next_node_addr), 32'(e_nxt));
        chk({tag, " length"}, 32'(length),         32'(q.size()));
        chk({tag, " head"},   32'(head),           32'(e_head()));
        chk({tag, " tail"},   32'(tail),           32'(e_tail()));
        chk({tag, " full"},   32'(full),           32'(q.size() == 15));
        chk({tag, " empty"},  32'(empty),          32'(q.size() == 0));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " op_done"}, 32'(op_done),        32'(0));
        chk({tag, " fault"},   32'(fault),          32'(0));
        chk({tag, " data"},    32'(data_out),       32'(0));
        chk({tag, " pre"},     32'(pre_node_addr),  32'(NUL));
        chk({tag, " next"},    32'(next_node_addr), 32'(NUL));
        chk({tag, " head"},    32'(head),           32'(NUL));
        chk({tag, " tail"},    32'(tail),           32'(NUL));
        chk({tag, " length"},  32'(length),         32'(0));
        chk({tag, " empty"},   32'(empty),          32'(1));
        chk({tag, " full"},    32'(full),           32'(0));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0; op_start = 1'b0;
        #1 chk_reset(tag);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
    endtask

    // called #1 after a rising edge; returns #1 after the op_done edge
    task automatic run_op(input logic [2:0] o, input logic [7:0] d, input logic [3:0] a,
                          input string tag);
        int lat;
        bit seen;
        model_op(o, d, a);
        op = o; data_in = d; addr_in = a; op_start = 1'b1;
        @(posedge clk); #1;
        op_start = 1'b0;
        op = 3'($urandom); data_in = 8'($urandom); addr_in = 4'($urandom);
        lat = 0; seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (op_done === 1'b1) seen = 1'b1;
        end
        chk({tag, " latency"}, 32'(lat), 32'(e_lat));
        compare_all(tag);
    endtask

    // ------------------------------------------------------------ vectors
    typedef struct {
        logic [2:0] o;
        logic [7:0] d;
        logic [3:0] a;
        logic       f;
        logic [7:0] dout;
        logic [3:0] pre, nxt, len, hd, tl;
    } vec_t;

    vec_t tbl[20];

    initial begin
        int hi_cnt;
        logic [3:0] len0;

        tbl[0]  = '{IT, 8'h11, 4'h0, 1'b0, 8'h11, NUL,  NUL,  4'd1, 4'h0, 4'h0};
        tbl[1]  = '{IT, 8'h22, 4'h0, 1'b0, 8'h22, 4'h0, NUL,  4'd2, 4'h0, 4'h1};
        tbl[2]  = '{IT, 8'h33, 4'h0, 1'b0, 8'h33, 4'h1, NUL,  4'd3, 4'h0, 4'h2};
        tbl[3]  = '{RD, 8'h00, 4'h1, 1'b0, 8'h22, 4'h0, 4'h2, 4'd3, 4'h0, 4'h2};
        tbl[4]  = '{RD, 8'h00, 4'h7, 1'b1, 8'h22, 4'h0, 4'h2, 4'd3, 4'h0, 4'h2};
        tbl[5]  = '{DA, 8'h00, 4'h1, 1'b0, 8'h22, 4'h0, 4'h2, 4'd2, 4'h0, 4'h2};
        tbl[6]  = '{IA, 8'h44, 4'h0, 1'b0, 8'h44, 4'h0, 4'h2, 4'd3, 4'h0, 4'h2};
        tbl[7]  = '{RD, 8'h00, 4'h1, 1'b0, 8'h44, 4'h0, 4'h2, 4'd3, 4'h0, 4'h2};
        tbl[8]  = '{RD, 8'h00, 4'h0, 1'b0, 8'h11, NUL,  4'h1, 4'd3, 4'h0, 4'h2};
        tbl[9]  = '{RD, 8'h00, 4'h2, 1'b0, 8'h33, 4'h1, NUL,  4'd3, 4'h0, 4'h2};
        tbl[10] = '{DH, 8'h00, 4'h0, 1'b0, 8'h11, NUL,  4'h1, 4'd2, 4'h1, 4'h2};
        tbl[11] = '{DT, 8'h00, 4'h0, 1'b0, 8'h33, 4'h1, NUL,  4'd1, 4'h1, 4'h1};
        tbl[12] = '{IA, 8'h55, 4'h1, 1'b0, 8'h55, 4'h1, NUL,  4'd2, 4'h1, 4'h0};
        tbl[13] = '{DA, 8'h00, 4'h1, 1'b0, 8'h44, NUL,  4'h0, 4'd1, 4'h0, 4'h0};
        tbl[14] = '{DH, 8'h00, 4'h0, 1'b0, 8'h55, NUL,  NUL,  4'd0, NUL,  NUL };
        tbl[15] = '{DH, 8'h00, 4'h0, 1'b1, 8'h55, NUL,  NUL,  4'd0, NUL,  NUL };
        tbl[16] = '{RD, 8'h00, NUL,  1'b1, 8'h55, NUL,  NUL,  4'd0, NUL,  NUL };
        tbl[17] = '{IA, 8'h66, 4'h0, 1'b1, 8'h55, NUL,  NUL,  4'd0, NUL,  NUL };
        tbl[18] = '{IH, 8'h77, 4'h0, 1'b0, 8'h77, NUL,  NUL,  4'd1, 4'h0, 4'h0};
        tbl[19] = '{RD, 8'h00, NUL,  1'b1, 8'h77, NUL,  NUL,  4'd1, 4'h0, 4'h0};

        // power-on reset
        model_reset();
        repeat (2) @(posedge clk);
        #1 chk_reset("por");
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // directed table
        for (int i = 0; i < 20; i++) begin
            run_op(tbl[i].o, tbl[i].d, tbl[i].a, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d tbl fault", i),  32'(fault),          32'(tbl[i].f));
            chk($sformatf("vec%0d tbl data", i),   32'(data_out),       32'(tbl[i].dout));
            chk($sformatf("vec%0d tbl pre", i),    32'(pre_node_addr),  32'(tbl[i].pre));
            chk($sformatf("vec%0d tbl next", i),   32'(next_node_addr), 32'(tbl[i].nxt));
            chk($sformatf("vec%0d tbl length", i), 32'(length),         32'(tbl[i].len));
            chk($sformatf("vec%0d tbl head", i),   32'(head),           32'(tbl[i].hd));
            chk($sformatf("vec%0d tbl tail", i),   32'(tail),           32'(tbl[i].tl));
        end

        // fill to capacity, then one more insert
        do_reset("rst fill");
        for (int i = 0; i < 15; i++) run_op(IH, 8'(8'h80 + i), 4'h0, "fill");
        run_op(IH, 8'hEE, 4'h0, "overfill");
        chk("overfill fault",  32'(fault),  32'(1));
        chk("overfill full",   32'(full),   32'(1));
        chk("overfill length", 32'(length), 32'(15));

        // DELETE_VALUE on 0x11,0x22,0x33
        do_reset("rst dv");
        run_op(IT, 8'h11, 4'h0, "dv setup");
        run_op(IT, 8'h22, 4'h0, "dv setup");
        run_op(IT, 8'h33, 4'h0, "dv setup");
        run_op(DV, 8'h33, 4'h0, "dv hit");
`ifdef DLL_CORE_DELETE_VALUE_EN
        chk("dv hit data", 32'(data_out), 32'(8'h33));
        chk("dv hit tail", 32'(tail),     32'(1));
`else
        chk("dv off fault", 32'(fault), 32'(1));
`endif
        run_op(DV, 8'h99, 4'h0, "dv miss");
        chk("dv miss fault", 32'(fault), 32'(1));

        // op_start held through EXEC must not launch a second op
        model_op(IT, 8'h5A, 4'h0);
        len0 = length;
        op = IT; data_in = 8'h5A; op_start = 1'b1;
        @(posedge clk); #1;
        op = IH; data_in = 8'hA5;
        @(posedge clk); #1;
        op_start = 1'b0;
        @(posedge clk); #1;
        chk("ignore op_done", 32'(op_done), 32'(1));
        compare_all("ignore");
        hi_cnt = 0;
        repeat (4) begin @(posedge clk); #1; if (op_done) hi_cnt++; end
        chk("ignore extra done", 32'(hi_cnt), 32'(0));
        chk("ignore length", 32'(length), 32'(len0 + 4'd1));

        // reset during an op in flight (SEARCH when op 7 is built in)
        op = DV; data_in = 8'hFE; op_start = 1'b1;
        @(posedge clk); #1;
        op_start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1 chk_reset("rst mid-op");
        @(negedge clk) rst = 1'b1;
        model_reset();
        hi_cnt = 0;
        repeat (6) begin @(posedge clk); #1; if (op_done) hi_cnt++; end
        chk("rst mid-op no done", 32'(hi_cnt), 32'(0));
        chk("rst mid-op length", 32'(length), 32'(0));

        // randomized traffic against the model
        for (int it = 0; it < 300; it++) begin
            logic [2:0] o;
            logic [7:0] d;
            logic [3:0] a;
            o = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) o = 3'($urandom_range(1, 3));
            d = 8'($urandom_range(0, 7));
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                a = 4'(q[$urandom_range(0, q.size() - 1)]);
            else
                a = 4'($urandom_range(0, 15));
            run_op(o, d, a, "rand");
        end

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
